// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-to-1 word multiplexer with valid/ready on every
// input channel and on the output. It supports direct-select and round-robin
// arbitration.
// Optional feature macro: MUX_XFER_CNT_EN adds a 16-bit output handshake
// counter (xfer_count).
module stream_mux_rr #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mode,
  input  logic [SEL_WIDTH-1:0]             select,
  input  logic [NUM_INPUTS*WORD_SIZE-1:0]  in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [WORD_SIZE-1:0]             out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SEL_WIDTH-1:0]             out_src
`ifdef MUX_XFER_CNT_EN
  ,
  output logic [15:0]                      xfer_count
`endif
);

  localparam int SLOTS = 1 << SEL_WIDTH;

  logic [WORD_SIZE-1:0] out_data_reg;
  logic                 out_valid_reg;
  logic [SEL_WIDTH-1:0] out_src_reg;
  logic [SEL_WIDTH-1:0] last_grant_reg;

  // Valid and data are padded to the full select range. An out-of-range
  // index then sees an idle channel and never produces a grant.
  logic [SLOTS-1:0]     valid_ext;
  logic [WORD_SIZE-1:0] chan_data [SLOTS];

  logic                 grant_found;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic [SEL_WIDTH-1:0] cand_idx;
  logic [SEL_WIDTH:0]   cand_sum;
  logic                 can_accept;
  logic                 xfer;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_INPUTS) begin : g_real
        assign valid_ext[gi] = in_valid[gi];
        assign chan_data[gi] = in_data[gi*WORD_SIZE +: WORD_SIZE];
      end else begin : g_pad
        assign valid_ext[gi] = 1'b0;
        assign chan_data[gi] = '0;
      end
    end
  endgenerate

  // Grant selection: direct index in mode 0. In mode 1, take the first valid
  // channel after last_grant, wrapping modulo NUM_INPUTS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    cand_sum    = '0;
    if (!mode) begin
      if (valid_ext[select]) begin
        grant_found = 1'b1;
        grant_idx   = select;
      end
    end else begin
      for (int k = 1; k <= NUM_INPUTS; k++) begin
        cand_sum = {1'b0, last_grant_reg} + (SEL_WIDTH+1)'(k);
        if (cand_sum >= (SEL_WIDTH+1)'(NUM_INPUTS))
          cand_sum = cand_sum - (SEL_WIDTH+1)'(NUM_INPUTS);
        cand_idx = cand_sum[SEL_WIDTH-1:0];
        if (!grant_found && valid_ext[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // The output slot is free when it is empty or when it drains this cycle.
  // Holding reset blocks every input transfer.
  assign can_accept = !out_valid_reg || out_ready;
  assign xfer       = rst_n && can_accept && grant_found;

  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
      assign in_ready[gi] = xfer && (grant_idx == SEL_WIDTH'(gi));
    end
  endgenerate

  // Output register and round-robin pointer. A new word replaces a draining
  // word in the same cycle, so no bubble is inserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_src_reg    <= '0;
      last_grant_reg <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else if (xfer) begin
      out_data_reg  <= chan_data[grant_idx];
      out_src_reg   <= grant_idx;
      out_valid_reg <= 1'b1;
      if (mode)
        last_grant_reg <= grant_idx;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_src   = out_src_reg;

`ifdef MUX_XFER_CNT_EN
  logic [15:0] xfer_count_reg;

  // Count completed output handshakes. The counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n)
      xfer_count_reg <= '0;
    else if (out_valid_reg && out_ready)
      xfer_count_reg <= xfer_count_reg + 16'd1;
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr (4 channels, 32 bits).
// An independent grant model predicts in_ready and queues the expected words.
// These are compared when the DUT presents them on the output handshake.
module tb_stream_mux_rr;

  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic [S-1:0] src;
  } sb_item_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [S-1:0]   select;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [S-1:0]   out_src;
`ifdef MUX_XFER_CNT_EN
  logic [15:0]    xfer_count;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  sb_item_t sb_q[$];

  // Reference model state, written only by the monitor
  logic         m_ov;
  logic [S-1:0] m_lg;
  logic [15:0]  m_cnt;

  stream_mux_rr #(.WORD_SIZE(W), .NUM_INPUTS(N), .SEL_WIDTH(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef MUX_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base | W'(i);
  endtask

  // Monitor at the falling edge. It predicts the grant, checks in_ready and
  // out_valid, pops the expected word on an output handshake, and pushes the
  // expected word on an input transfer.
  always @(negedge clk) begin
    logic         acc;
    logic         found;
    int           gidx;
    logic [N-1:0] exp_ready;
    sb_item_t     it;
    if (!rst_n) begin
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      sb_q.delete();
      m_ov  = 1'b0;
      m_lg  = S'(N - 1);
      m_cnt = 16'd0;
    end else begin
      check_eq("out_valid", 64'(out_valid), 64'(m_ov));
`ifdef MUX_XFER_CNT_EN
      check_eq("xfer_count", 64'(xfer_count), 64'(m_cnt));
`endif
      acc   = !m_ov || out_ready;
      found = 1'b0;
      gidx  = 0;
      if (!mode) begin
        if (int'(select) < N && in_valid[select]) begin
          found = 1'b1;
          gidx  = int'(select);
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!found && in_valid[(int'(m_lg) + k) % N]) begin
            found = 1'b1;
            gidx  = (int'(m_lg) + k) % N;
          end
        end
      end
      exp_ready = (acc && found) ? N'(1) << gidx : '0;
      check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
      if (m_ov && out_ready) begin
        m_cnt = m_cnt + 16'd1;
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          it = sb_q.pop_front();
          check_eq("out_data", 64'(out_data), 64'(it.data));
          check_eq("out_src", 64'(out_src), 64'(it.src));
        end
      end
      if (exp_ready != '0) begin
        it.data = in_data[gidx*W +: W];
        it.src  = S'(gidx);
        sb_q.push_back(it);
        m_ov = 1'b1;
        if (mode) m_lg = S'(gidx);
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    select    = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_data(32'hA0A0_0000);

    // Reset with every channel valid
    repeat (2) step();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_src", 64'(out_src), 64'd0);
    check_eq("rst_ready_hold", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("first_rr_grant", 64'(in_ready), 64'b0001);
    step();
    check_eq("first_rr_src", 64'(out_src), 64'd0);

    // Direct select of channel 2
    mode = 1'b0;
    select = 2'd2;
    set_data(32'hCAFE_0000);
    #1;
    check_eq("direct_ready", 64'(in_ready), 64'b0100);
    step();
    check_eq("direct_data", 64'(out_data), 64'hCAFE_0002);
    check_eq("direct_src", 64'(out_src), 64'd2);
    in_valid = '0;
    step();

    // Round-robin fairness from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mode = 1'b1;
    in_valid = '1;
    set_data(32'h5500_0000);
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("rr_src", 64'(out_src), 64'(k % 4));
      check_eq("rr_valid", 64'(out_valid), 64'd1);
    end

    // Sparse round-robin: channels 1 and 3 alternate, then only channel 1
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("sparse_src", 64'(out_src), (k % 2) ? 64'd3 : 64'd1);
    end
    in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("single_src", 64'(out_src), 64'd1);
    end
    in_valid = '0;
    repeat (2) step();

    // Backpressure holds the output and blocks every input
    mode = 1'b0;
    select = 2'd0;
    in_data[0 +: W] = 32'h1111_1111;
    in_valid = 4'b0001;
    out_ready = 1'b0;
    step();
    in_valid = '1;
    for (int k = 0; k < 3; k++) begin
      set_data($urandom);
      step();
      check_eq("bp_data", 64'(out_data), 64'h1111_1111);
      check_eq("bp_src", 64'(out_src), 64'd0);
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      check_eq("bp_ready", 64'(in_ready), 64'd0);
    end
    in_data[0 +: W] = 32'h2222_2222;
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(in_ready), 64'b0001);
    step();
    check_eq("bp_nobubble_data", 64'(out_data), 64'h2222_2222);
    check_eq("bp_nobubble_valid", 64'(out_valid), 64'd1);
    in_valid = '0;
    step();
    check_eq("drain_valid", 64'(out_valid), 64'd0);
    check_eq("drain_hold_data", 64'(out_data), 64'h2222_2222);

    // Reset while a word waits under backpressure
    in_valid = 4'b0001;
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = '0;
    step();

    // Random traffic checked by the scoreboard
    for (int k = 0; k < 300; k++) begin
      mode      = 1'($urandom);
      select    = S'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      set_data($urandom & 32'hFFFF_FFF0);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

`ifdef MUX_XFER_CNT_EN
    // Counter wrap: 65537 handshakes leave a count of 1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mode = 1'b1;
    in_valid = '1;
    step();
    repeat (65537) step();
    check_eq("cnt_wrap", 64'(xfer_count), 64'd1);
    rst_n = 1'b0;
    step();
    check_eq("cnt_reset", 64'(xfer_count), 64'd0);
    rst_n = 1'b1;
    in_valid = '0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
